// File: rtl/frame_dumper.sv
// frame_dumper: reads one frame out of display memory word by word and
// serialises every colour component as an MSB-aligned byte on a valid/ready
// stream (row, column, segment, then R, G, B).
// Optional feature: define FRAME_DUMPER_CHECKSUM_EN to append one byte holding
// the XOR of all pixel bytes of the dump; done then pulses on that byte.
module frame_dumper #(
  parameter int segments = 2,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [$clog2(rows)-1:0]             rrow,
  output logic [$clog2(columns)-1:0]          rcol,
  input  logic [bitwidth*3*segments-1:0]      rdata,
  output logic [7:0]                          odata,
  output logic                                ovalid,
  input  logic                                oready
);

  localparam int row_w  = $clog2(rows);
  localparam int col_w  = $clog2(columns);
  localparam int seg_w  = (segments > 1) ? $clog2(segments) : 1;
  localparam int word_w = bitwidth * 3 * segments;
  localparam int pad_w  = 8 - bitwidth;

  localparam logic [row_w-1:0] ROW_LAST = row_w'(rows - 1);
  localparam logic [col_w-1:0] COL_LAST = col_w'(columns - 1);
  localparam logic [seg_w-1:0] SEG_LAST = seg_w'(segments - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
`ifdef FRAME_DUMPER_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM = 3'd4;
`endif

  // Picks component comp (0=R, 1=G, 2=B) of segment seg out of a memory word
  // and left-aligns it in a byte, leaving the low bits zero.
  function automatic logic [7:0] enc_byte(input logic [word_w-1:0] w,
                                          input logic [seg_w-1:0]  seg,
                                          input logic [1:0]        comp);
    logic [bitwidth-1:0] c;
    int unsigned         off;
    off = (int'(seg) * 3 + 2 - int'(comp)) * bitwidth;
    c   = bitwidth'(w >> off);
    return 8'(c) << pad_w;
  endfunction

  logic [2:0]        state_r;
  logic [word_w-1:0] word_r;
  logic [seg_w-1:0]  seg_r;
  logic [1:0]        comp_r;
`ifdef FRAME_DUMPER_CHECKSUM_EN
  logic [7:0]        csum_r;
`endif

  logic              xfer_s;
  logic              last_byte_s;
  logic              last_word_s;
  logic [seg_w-1:0]  nxt_seg_s;
  logic [1:0]        nxt_comp_s;
  logic [7:0]        nxt_byte_s;

  // Handshake decode and the next (segment, component) position within the word.
  always_comb begin
    xfer_s      = ovalid && oready;
    last_byte_s = (comp_r == 2'd2) && (seg_r == SEG_LAST);
    last_word_s = (rrow == ROW_LAST) && (rcol == COL_LAST);
    if (comp_r == 2'd2) begin
      nxt_comp_s = 2'd0;
      nxt_seg_s  = seg_r + seg_w'(1);
    end else begin
      nxt_comp_s = comp_r + 2'd1;
      nxt_seg_s  = seg_r;
    end
    nxt_byte_s = enc_byte(word_r, nxt_seg_s, nxt_comp_s);
  end

  // Main sequencer: fetch a word (READ, WAIT), stream its bytes (SEND), repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      word_r  <= '0;
      seg_r   <= '0;
      comp_r  <= 2'd0;
      rrow    <= '0;
      rcol    <= '0;
      odata   <= 8'd0;
      ovalid  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef FRAME_DUMPER_CHECKSUM_EN
      csum_r  <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_READ;
            busy    <= 1'b1;
`ifdef FRAME_DUMPER_CHECKSUM_EN
            csum_r  <= 8'd0;
`endif
          end
        end
        ST_READ: begin
          // rrow/rcol already hold the address of the word to fetch.
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // Memory data is valid now; the first byte is taken straight from it.
          word_r  <= rdata;
          seg_r   <= '0;
          comp_r  <= 2'd0;
          odata   <= enc_byte(rdata, '0, 2'd0);
          ovalid  <= 1'b1;
          state_r <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer_s) begin
`ifdef FRAME_DUMPER_CHECKSUM_EN
            csum_r <= csum_r ^ odata;
`endif
            if (!last_byte_s) begin
              comp_r <= nxt_comp_s;
              seg_r  <= nxt_seg_s;
              odata  <= nxt_byte_s;
            end else begin
              if (rcol == COL_LAST) begin
                rcol <= '0;
                rrow <= (rrow == ROW_LAST) ? '0 : rrow + row_w'(1);
              end else begin
                rcol <= rcol + col_w'(1);
              end
              if (last_word_s) begin
`ifdef FRAME_DUMPER_CHECKSUM_EN
                // Keep ovalid high and present the folded checksum next.
                odata   <= csum_r ^ odata;
                state_r <= ST_CSUM;
`else
                ovalid  <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                state_r <= ST_IDLE;
`endif
              end else begin
                ovalid  <= 1'b0;
                state_r <= ST_READ;
              end
            end
          end
        end
`ifdef FRAME_DUMPER_CHECKSUM_EN
        ST_CSUM: begin
          if (xfer_s) begin
            ovalid  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
`endif
        default: begin
          ovalid  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
